// File: rtl/cpu_core_mc.sv
// cpu_core_mc: multi-cycle accumulator CPU core with register file, call stack and data-memory handshake
module cpu_core_mc #(
    parameter int DATA_W      = 8,
    parameter int PC_W        = 5,
    parameter int DM_AW       = 10,
    parameter int REG_N       = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              clr,
    output logic [PC_W-1:0]   pm_addr,
    input  logic [15:0]       pm_data,
    output logic              dm_req,
    output logic              dm_we,
    output logic [DM_AW-1:0]  dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic [DATA_W-1:0] dm_rdata,
    input  logic              dm_ack,
    output logic [DATA_W-1:0] o_data,
    output logic [1:0]        flags,
    output logic              halted,
    output logic              err
);
    localparam int RW = $clog2(REG_N);
    localparam int SW = $clog2(STACK_DEPTH + 1);
    localparam logic [1:0] FETCH = 2'd0, EXEC = 2'd1, MEM = 2'd2, STOP = 2'd3;
    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);
    localparam logic [SW-1:0] SP_ONE = SW'(1);
    localparam logic [SW-1:0] SP_FULL = SW'(STACK_DEPTH);
    logic [1:0]        state;
    logic [PC_W-1:0]   pc, pc_inc, target;
    logic [SW-1:0]     sp;
    logic [DATA_W-1:0] acc, rv, imm, acc_n;
    logic [DATA_W:0]   sum, diff;
    logic              c, z, c_n, c_we, acc_we, mem_we, unused;
    logic [3:0]        op;
    logic [RW-1:0]     r;
    logic [DM_AW-1:0]  mem_addr;
    logic [DATA_W-1:0] regs [REG_N];
    logic [PC_W-1:0]   stack [2**SW];
    assign op = pm_data[15:12];
    assign r = pm_data[RW-1:0];
    assign target = pm_data[PC_W-1:0];
    assign imm = DATA_W'(pm_data[7:0]);
    assign rv = regs[r];
    assign sum = {1'b0, acc} + {1'b0, rv};
    assign diff = {1'b0, acc} - {1'b0, rv};
    assign pc_inc = pc + PC_ONE;
    assign unused = ^pm_data;
    assign pm_addr = pc;
    assign dm_req = state == MEM;
    assign dm_we = dm_req && mem_we;
    assign dm_addr = mem_addr;
    assign dm_wdata = acc;
    assign o_data = acc;
    assign flags = {c, z};
    // ALU result and flag-update enables for the instruction being executed
    always_comb begin
        acc_n = '0;
        acc_we = 1'b1;
        c_we = 1'b0;
        c_n = 1'b0;
        case (op)
            4'h1: acc_n = imm;
            4'h2: acc_n = rv;
            4'h4: {c_we, c_n, acc_n} = {1'b1, sum};
            4'h5: {c_we, c_n, acc_n} = {1'b1, diff};
            4'h6: {c_we, acc_n} = {1'b1, acc & rv};
            4'h7: {c_we, acc_n} = {1'b1, acc | rv};
            4'h8: {c_we, acc_n} = {1'b1, acc ^ rv};
            default: acc_we = 1'b0;
        endcase
    end
    // FETCH/EXEC/MEM/STOP sequencing with architectural state updates
    always_ff @(posedge clk) begin
        if (!clr) begin
            state <= FETCH;
            pc <= '0;
            acc <= '0;
            c <= 1'b0;
            z <= 1'b0;
            sp <= '0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            halted <= 1'b0;
            err <= 1'b0;
            for (int i = 0; i < REG_N; i++) regs[i] <= '0;
        end else begin
            case (state)
                FETCH: state <= EXEC;
                EXEC: begin
                    state <= FETCH;
                    pc <= pc_inc;
                    if (acc_we) begin
                        acc <= acc_n;
                        z <= acc_n == '0;
                    end
                    if (c_we) c <= c_n;
                    case (op)
                        4'h3: regs[r] <= acc;
                        4'h9, 4'hA: begin
                            pc <= pc;
                            mem_we <= op == 4'hA;
                            mem_addr <= pm_data[DM_AW-1:0];
                            state <= MEM;
                        end
                        4'hB: pc <= target;
                        4'hC: if (z) pc <= target;
                        4'hD: if (c) pc <= target;
                        4'hE: begin
                            if (sp == SP_FULL) begin
                                pc <= pc;
                                err <= 1'b1;
                                halted <= 1'b1;
                                state <= STOP;
                            end else begin
                                stack[sp] <= pc_inc;
                                sp <= sp + SP_ONE;
                                pc <= target;
                            end
                        end
                        4'hF: begin
                            if (pm_data[0] || sp == '0) begin
                                pc <= pc;
                                err <= !pm_data[0];
                                halted <= 1'b1;
                                state <= STOP;
                            end else begin
                                pc <= stack[sp - SP_ONE];
                                sp <= sp - SP_ONE;
                            end
                        end
                        default: ;
                    endcase
                end
                MEM: begin
                    if (dm_ack) begin
                        if (!mem_we) begin
                            acc <= dm_rdata;
                            z <= dm_rdata == '0;
                        end
                        pc <= pc_inc;
                        state <= FETCH;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_core_mc.sv
// tb_cpu_core_mc: directed-vector bench for cpu_core_mc with program and data memory models
module tb_cpu_core_mc;
    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic [4:0]  pm_addr;
    logic [15:0] pm_data = '0;
    logic        dm_req, dm_we;
    logic [9:0]  dm_addr;
    logic [7:0]  dm_wdata, dm_rdata;
    logic        dm_ack = 1'b0;
    logic [7:0]  o_data;
    logic [1:0]  flags;
    logic        halted, err;
    logic [15:0] pm [32];
    logic [7:0]  dmem [1024];
    logic [7:0]  val;
    logic [4:0]  rets [4];
    int total = 0;
    int bad = 0;
    cpu_core_mc dut (
        .clk(clk), .clr(clr), .pm_addr(pm_addr), .pm_data(pm_data),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack), .o_data(o_data), .flags(flags),
        .halted(halted), .err(err)
    );
    always #5 clk = ~clk;
    // synchronous program memory: word appears the cycle after its address
    always @(posedge clk) pm_data <= pm[pm_addr];
    // data memory stores on an acknowledged write
    always @(posedge clk) if (dm_req && dm_ack && dm_we) dmem[dm_addr] <= dm_wdata;
    assign dm_rdata = dmem[dm_addr];
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic do_reset();
        clr = 1'b0;
        step(2);
        clr = 1'b1;
    endtask
    task automatic clear_pm();
        for (int i = 0; i < 32; i++) pm[i] = 16'h0000;
    endtask
    initial begin
        @(negedge clk);
        clear_pm();
        pm[0] = 16'h10FF; pm[1] = 16'h3001; pm[2] = 16'h1001; pm[3] = 16'h4001;
        pm[4] = 16'hC006; pm[5] = 16'hF001; pm[6] = 16'hD008; pm[7] = 16'hF001;
        pm[8] = 16'h1002; pm[9] = 16'h5001; pm[10] = 16'hC005; pm[11] = 16'h6001;
        pm[12] = 16'hD005; pm[13] = 16'hF001;
        do_reset();
        step(2);
        check("ldi_ff", 32'(o_data), 32'hFF);
        clr = 1'b0;
        step(3);
        check("rst_pc", 32'(pm_addr), 0);
        check("rst_acc", 32'(o_data), 0);
        check("rst_flags", 32'(flags), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_err", 32'(err), 0);
        check("rst_req", 32'(dm_req), 0);
        clr = 1'b1;
        step(1);
        check("exec_not_c1", 32'(o_data), 0);
        step(1);
        check("exec_c2", 32'(o_data), 32'hFF);
        step(6);
        check("add_acc", 32'(o_data), 0);
        check("add_flags", 32'(flags), 3);
        step(2);
        check("jz_taken", 32'(pm_addr), 6);
        step(2);
        check("jc_taken", 32'(pm_addr), 8);
        step(4);
        check("sub_acc", 32'(o_data), 3);
        check("sub_flags", 32'(flags), 2);
        step(2);
        check("jz_not", 32'(pm_addr), 11);
        step(2);
        check("and_acc", 32'(o_data), 3);
        check("and_flags", 32'(flags), 0);
        step(2);
        check("jc_not", 32'(pm_addr), 13);
        step(2);
        check("halt_h", 32'(halted), 1);
        check("halt_err", 32'(err), 0);
        check("halt_pc", 32'(pm_addr), 13);
        step(4);
        check("halt_hold", 32'(pm_addr), 13);
        clear_pm();
        pm[0] = 16'hB01F;
        do_reset();
        step(2);
        check("jmp_top", 32'(pm_addr), 31);
        step(2);
        check("pc_wrap", 32'(pm_addr), 0);
        clear_pm();
        pm[0] = 16'hE00A; pm[1] = 16'hF001; pm[10] = 16'hE014; pm[11] = 16'hF000;
        pm[20] = 16'hE018; pm[21] = 16'hF000; pm[24] = 16'hE01C; pm[25] = 16'hF000;
        pm[28] = 16'hF000;
        rets[0] = 5'd25; rets[1] = 5'd21; rets[2] = 5'd11; rets[3] = 5'd1;
        do_reset();
        step(8);
        check("call_deep", 32'(pm_addr), 28);
        for (int i = 0; i < 4; i++) begin
            step(2);
            check($sformatf("ret%0d", i), 32'(pm_addr), 32'(rets[i]));
        end
        step(2);
        check("stk_halt", 32'(halted), 1);
        check("stk_noerr", 32'(err), 0);
        clear_pm();
        pm[0] = 16'hE002; pm[2] = 16'hE004; pm[4] = 16'hE006; pm[6] = 16'hE008; pm[8] = 16'hE00A;
        do_reset();
        step(8);
        check("ovf_pre_err", 32'(err), 0);
        step(2);
        check("ovf_err", 32'(err), 1);
        check("ovf_halt", 32'(halted), 1);
        check("ovf_pc", 32'(pm_addr), 8);
        step(3);
        check("ovf_frozen", 32'(pm_addr), 8);
        clear_pm();
        pm[1] = 16'hF000;
        do_reset();
        step(4);
        check("udf_err", 32'(err), 1);
        check("udf_halt", 32'(halted), 1);
        check("udf_pc", 32'(pm_addr), 1);
        for (int d = 0; d < 4; d++) begin
            val = (d == 0) ? 8'hA5 : (d == 1) ? 8'h5A : (d == 2) ? 8'hC3 : 8'h3C;
            clear_pm();
            pm[0] = {8'h10, val}; pm[1] = 16'hA005; pm[2] = 16'h1000; pm[3] = 16'h9005; pm[4] = 16'hF001;
            do_reset();
            step(4);
            for (int w = 0; w <= d; w++) begin
                check($sformatf("stm_req_d%0d_%0d", d, w), 32'(dm_req), 1);
                check($sformatf("stm_we_d%0d_%0d", d, w), 32'(dm_we), 1);
                check($sformatf("stm_addr_d%0d_%0d", d, w), 32'(dm_addr), 5);
                check($sformatf("stm_wdata_d%0d_%0d", d, w), 32'(dm_wdata), 32'(val));
                if (w < d) step(1);
            end
            dm_ack = 1'b1;
            step(1);
            dm_ack = 1'b0;
            check($sformatf("stm_done_d%0d", d), 32'(dm_req), 0);
            check($sformatf("stm_pc_d%0d", d), 32'(pm_addr), 2);
            step(2);
            check($sformatf("ldi0_flags_d%0d", d), 32'(flags), 1);
            step(2);
            check($sformatf("ldm_req_d%0d", d), 32'(dm_req), 1);
            check($sformatf("ldm_we_d%0d", d), 32'(dm_we), 0);
            dm_ack = 1'b1;
            step(1);
            dm_ack = 1'b0;
            check($sformatf("ldm_acc_d%0d", d), 32'(o_data), 32'(val));
            check($sformatf("ldm_flags_d%0d", d), 32'(flags), 0);
            dm_ack = 1'b1;
            step(1);
            dm_ack = 1'b0;
            step(1);
            check($sformatf("spur_halt_d%0d", d), 32'(halted), 1);
            check($sformatf("spur_pc_d%0d", d), 32'(pm_addr), 4);
            check($sformatf("spur_acc_d%0d", d), 32'(o_data), 32'(val));
        end
        clear_pm();
        pm[0] = 16'hA007;
        do_reset();
        step(2);
        check("mrst_req", 32'(dm_req), 1);
        step(3);
        check("mrst_wait", 32'(dm_req), 1);
        clr = 1'b0;
        step(1);
        check("mrst_req0", 32'(dm_req), 0);
        check("mrst_we0", 32'(dm_we), 0);
        check("mrst_pc", 32'(pm_addr), 0);
        clr = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
